// File: rtl/hazard_pkg.sv
// Package for the scoreboard hazard controller.
// Provides RV32I opcode constants (for decode-side users of this controller),
// the flush FSM state type and a helper that sizes down-counters.
package hazard_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // funct7 value selecting the M extension within OP_OP
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // state | meaning
    // IDLE  | no flush in progress (a mispredict still flushes combinationally)
    // FLUSH | extra flush cycles after a mispredict, counter counts them down
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

    // Width of a down-counter that must hold values 0..max_lat.
    function automatic int lat_w(input int max_lat);
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: one latency down-counter per architectural register
// plus the mul/div unit busy counter.
// Ports:
//   clk, rst      clock, async active-high reset
//   issue_i       ID instruction issues this cycle
//   rd_i          destination of the issuing instruction
//   is_load_i     issuing instruction is a load
//   is_muldiv_i   issuing instruction is a mul/div
//   pending_o     bit r set while register r's result is not yet forwardable
//   md_busy_o     mul/div unit still busy
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 4,
    localparam int AW = $clog2(NREGS),
    localparam int TW = lat_w((LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_i,
    input  logic [AW-1:0]    rd_i,
    input  logic             is_load_i,
    input  logic             is_muldiv_i,
    output logic [NREGS-1:0] pending_o,
    output logic             md_busy_o
);

    logic [TW-1:0] timer_q [NREGS];
    logic [TW-1:0] timer_d [NREGS];
    logic [TW-1:0] md_q, md_d;
    logic [TW-1:0] set_lat;

    always_comb begin
        // Longer latency wins if an instruction is flagged as both.
        set_lat = '0;
        if (is_load_i)
            set_lat = TW'(LOAD_LAT);
        if (is_muldiv_i && (TW'(MD_LAT) > set_lat))
            set_lat = TW'(MD_LAT);

        for (int r = 0; r < NREGS; r++) begin
            timer_d[r] = (timer_q[r] != '0) ? timer_q[r] - TW'(1) : '0;
            // x0 is never tracked; an issue only raises a timer (WAW safe).
            if ((r != 0) && issue_i && (rd_i == AW'(r)) && (timer_d[r] < set_lat))
                timer_d[r] = set_lat;
            pending_o[r] = (timer_q[r] != '0);
        end

        md_d = (md_q != '0) ? md_q - TW'(1) : '0;
        if (issue_i && is_muldiv_i && (rd_i != '0))
            md_d = TW'(MD_LAT);
    end

    assign md_busy_o = (md_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                timer_q[r] <= '0;
            md_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                timer_q[r] <= timer_d[r];
            md_q <= md_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Scoreboard-based hazard controller sitting beside ID.
// Compares ID source operands against the scoreboard, interlocks mul/div,
// and sequences the pipeline flush on a branch mispredict from EX.
// Ports:
//   clk, rst                    clock, async active-high reset
//   id_*                        decode info of the instruction in ID
//   ex_is_branch, ex_mispredict branch resolution from EX
//   stall, bubble, pc_write     interlock controls
//   flush_if_id, flush_id_ex    squash controls
//   redirect                    select corrected PC target
//   sb_pending                  per-register pending view of the scoreboard
module hazard_ctrl_sb
    import hazard_pkg::*;
#(
    parameter int NREGS        = 32,
    parameter int LOAD_LAT     = 1,
    parameter int MD_LAT       = 4,
    parameter int FLUSH_CYCLES = 1,
    localparam int AW = $clog2(NREGS),
    localparam int FW = lat_w(FLUSH_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_is_load,
    input  logic             id_is_muldiv,
    input  logic             ex_is_branch,
    input  logic             ex_mispredict,
    output logic             stall,
    output logic             bubble,
    output logic             pc_write,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             redirect,
    output logic [NREGS-1:0] sb_pending
);

    flush_state_t  state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          mispredict;
    logic          flushing;
    logic          hazard;
    logic          issue;
    logic          md_busy;

    hazard_scoreboard #(
        .NREGS    (NREGS),
        .LOAD_LAT (LOAD_LAT),
        .MD_LAT   (MD_LAT)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (issue),
        .rd_i        (id_rd),
        .is_load_i   (id_is_load),
        .is_muldiv_i (id_is_muldiv),
        .pending_o   (sb_pending),
        .md_busy_o   (md_busy)
    );

    assign mispredict = ex_is_branch && ex_mispredict;
    assign flushing   = mispredict || (state_q == FLUSH);

    assign hazard = (id_use_rs1 && (id_rs1 != '0) && sb_pending[id_rs1]) ||
                    (id_use_rs2 && (id_rs2 != '0) && sb_pending[id_rs2]) ||
                    (id_is_muldiv && md_busy);

    assign stall       = id_valid && hazard && !flushing;
    assign bubble      = stall;
    assign pc_write    = !stall || flushing;
    assign issue       = id_valid && !stall && !flushing;
    assign flush_if_id = flushing;
    assign flush_id_ex = flushing;
    assign redirect    = mispredict;

    // Counter holds the flush cycles still owed after the current one.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (mispredict) begin
            fcnt_d  = FW'(FLUSH_CYCLES - 1);
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
        end else if (state_q == FLUSH) begin
            fcnt_d = fcnt_q - FW'(1);
            if (fcnt_d == '0)
                state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
module tb_hazard_ctrl_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_is_load, id_is_muldiv;
    logic        ex_is_branch, ex_mispredict;
    logic        stall, bubble, pc_write, flush_if_id, flush_id_ex, redirect;
    logic [31:0] sb_pending;

    int errors = 0;
    int checks = 0;

    hazard_ctrl_sb #(
        .NREGS(32), .LOAD_LAT(1), .MD_LAT(4), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv),
        .ex_is_branch(ex_is_branch), .ex_mispredict(ex_mispredict),
        .stall(stall), .bubble(bubble), .pc_write(pc_write),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .redirect(redirect), .sb_pending(sb_pending)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input int rs1, input int rs2,
                          input logic u1, input logic u2, input int rd,
                          input logic ld, input logic md);
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
        id_use_rs1 = u1; id_use_rs2 = u2; id_rd = 5'(rd);
        id_is_load = ld; id_is_muldiv = md;
        #1;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_is_branch = 0; ex_mispredict = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: stall=%b bubble=%b pc_write=%b, required 0 0 1", stall, bubble, pc_write);
        end
        checks++;
        if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0 || redirect !== 1'b0 || sb_pending !== 32'h0) begin
            errors++;
            $display("FAIL reset_flush: fif=%b fie=%b redir=%b pend=%h, required 0 0 0 0", flush_if_id, flush_id_ex, redirect, sb_pending);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        set_id(1, 1, 0, 1, 0, 5, 1, 0);           // lw x5, 0(x1)
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL lu_load_issue: stall=%b, required 0", stall); end
        tick();
        set_id(1, 5, 1, 1, 1, 6, 0, 0);           // add x6, x5, x1
        checks++;
        if (stall !== 1'b1 || bubble !== 1'b1 || pc_write !== 1'b0 || sb_pending[5] !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall: stall=%b bubble=%b pc_write=%b pend5=%b, required 1 1 0 1", stall, bubble, pc_write, sb_pending[5]);
        end
        tick();
        checks++;
        if (stall !== 1'b0 || pc_write !== 1'b1 || sb_pending !== 32'h0) begin
            errors++;
            $display("FAIL lu_issue: stall=%b pc_write=%b pend=%h, required 0 1 0", stall, pc_write, sb_pending);
        end
        idle(2);
    endtask

    task automatic test_muldiv();
        int n;
        set_id(1, 1, 2, 1, 1, 7, 0, 1);           // mul x7, x1, x2
        tick();
        set_id(1, 7, 7, 1, 1, 8, 0, 0);           // add x8, x7, x7
        n = 0;
        for (int i = 0; i < 10 && stall === 1'b1; i++) begin
            if (i == 3) begin
                checks++;
                if (sb_pending[7] !== 1'b1) begin errors++; $display("FAIL md_pend_last: pend7=%b, required 1", sb_pending[7]); end
            end
            n++;
            tick();
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL md_stall_count: got %0d cycles, required 4", n); end
        checks++;
        if (sb_pending[7] !== 1'b0 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL md_release: pend7=%b pc_write=%b, required 0 1", sb_pending[7], pc_write);
        end
        idle(5);
    endtask

    task automatic test_x0();
        set_id(1, 1, 0, 1, 0, 0, 1, 0);           // lw x0, 0(x1)
        tick();
        set_id(1, 0, 0, 1, 1, 9, 0, 0);           // add x9, x0, x0
        checks++;
        if (stall !== 1'b0 || sb_pending !== 32'h0) begin
            errors++;
            $display("FAIL x0_no_stall: stall=%b pend=%h, required 0 0", stall, sb_pending);
        end
        idle(2);
    endtask

    task automatic test_mispredict();
        ex_is_branch = 1'b0; ex_mispredict = 1'b1; // mispredict without branch is ignored
        set_id(1, 1, 0, 1, 0, 5, 1, 0);           // lw x5
        checks++;
        if (flush_if_id !== 1'b0 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL mp_not_branch: flush=%b redir=%b, required 0 0", flush_if_id, redirect);
        end
        tick();
        ex_is_branch = 1'b1; ex_mispredict = 1'b1;
        set_id(1, 5, 0, 1, 0, 6, 1, 0);           // lw x6, 0(x5): hazard on x5
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0 || pc_write !== 1'b1 || redirect !== 1'b1 ||
            flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
            errors++;
            $display("FAIL mp_cycle0: stall=%b bubble=%b pcw=%b redir=%b fif=%b fie=%b, required 0 0 1 1 1 1",
                     stall, bubble, pc_write, redirect, flush_if_id, flush_id_ex);
        end
        tick();
        ex_is_branch = 1'b0; ex_mispredict = 1'b0;
        set_id(1, 1, 0, 1, 0, 10, 1, 0);          // lw x10, squashed
        checks++;
        if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1 || redirect !== 1'b0 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL mp_cycle1: fif=%b fie=%b redir=%b pcw=%b, required 1 1 0 1", flush_if_id, flush_id_ex, redirect, pc_write);
        end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0 || redirect !== 1'b0 || sb_pending !== 32'h0) begin
            errors++;
            $display("FAIL mp_cycle2: fif=%b fie=%b redir=%b pend=%h, required 0 0 0 0", flush_if_id, flush_id_ex, redirect, sb_pending);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int n;
        set_id(1, 1, 0, 1, 0, 3, 1, 0);           // lw x3
        tick();
        set_id(1, 1, 2, 1, 1, 3, 0, 1);           // mul x3, x1, x2 (WAW)
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL waw_mul_issue: stall=%b, required 0", stall); end
        tick();
        set_id(1, 3, 0, 1, 0, 4, 0, 0);           // add x4, x3, x0
        n = 0;
        for (int i = 0; i < 10 && stall === 1'b1; i++) begin n++; tick(); end
        checks++;
        if (n != 4) begin errors++; $display("FAIL waw_stall_count: got %0d cycles, required 4", n); end
        idle(5);
        // Independent mul behind a mul waits for the unit.
        set_id(1, 1, 2, 1, 1, 11, 0, 1);          // mul x11
        tick();
        set_id(1, 1, 2, 1, 1, 12, 0, 1);          // mul x12, independent
        n = 0;
        for (int i = 0; i < 10 && stall === 1'b1; i++) begin n++; tick(); end
        checks++;
        if (n != 4) begin errors++; $display("FAIL md_busy_count: got %0d cycles, required 4", n); end
        idle(6);
    endtask

    task automatic test_reset_mid_stall();
        set_id(1, 1, 2, 1, 1, 7, 0, 1);           // mul x7
        tick();
        set_id(1, 7, 0, 1, 0, 8, 0, 0);           // add x8, x7
        tick();
        tick();                                   // now in 3rd stall cycle
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: stall=%b, required 1", stall); end
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || pc_write !== 1'b1 || sb_pending !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_stall: stall=%b pcw=%b pend=%h, required 0 1 0", stall, pc_write, sb_pending);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (stall !== 1'b0 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL rst_after: stall=%b pcw=%b, required 0 1", stall, pc_write);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_muldiv();
        test_x0();
        test_mispredict();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
